accum_delta_decoder: RTL and testbench

//  Inverse of the running-sum accumulator. It consumes the accumulator's SUM_W-bit output

---
 rtl/accum_delta_decoder_if.sv | 27 ++
 rtl/accum_delta_decoder.sv | 111 +++++++++++
 tb/tb_accum_delta_decoder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_delta_decoder_if.sv
// rtl/accum_delta_decoder_if.sv - handshake bundle between a driver and the delta decoder
interface accum_delta_decoder_if #(
  parameter int SUM_W   = 7,
  parameter int DELTA_W = 4,
  parameter int CNT_W   = 8
);
  logic               resync;
  logic               in_valid;
  logic               in_ready;
  logic [SUM_W-1:0]   in_sum;
  logic               out_valid;
  logic               out_ready;
  logic [DELTA_W-1:0] out_delta;
  logic               out_err;
  logic [CNT_W-1:0]   err_cnt;
  logic               primed;

  modport master (
    output resync, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_delta, out_err, err_cnt, primed
  );

  modport slave (
    input  resync, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_delta, out_err, err_cnt, primed
  );
endinterface

// File: rtl/accum_delta_decoder.sv
// rtl/accum_delta_decoder.sv - recovers per-sample increments from a running-sum accumulator stream
module accum_delta_decoder #(
  parameter int SUM_W   = 7,
  parameter int DELTA_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  accum_delta_decoder_if.slave  bus
);

  typedef enum logic {PRIME, RUN} state_t;

  state_t             state;
  logic               primed_q;
  logic [SUM_W-2:0]   base;
  logic [CNT_W-1:0]   err_cnt_q;

  // Two-entry FIFO kept as explicit head/tail registers so the head is a plain flop output
  logic [1:0]         count;
  logic [DELTA_W-1:0] head_delta;
  logic               head_err;
  logic [DELTA_W-1:0] tail_delta;
  logic               tail_err;

  logic               in_ready;
  logic               accept;
  logic               push;
  logic               pop;
  logic [SUM_W:0]     diff;
  logic               err;
  logic [DELTA_W-1:0] delta;

  assign in_ready = !rst && !bus.resync && (count < 2'd2);
  assign accept   = bus.in_valid && in_ready;
  assign push     = accept && (state == RUN);
  assign pop      = (count != 2'd0) && bus.out_ready;

  // Baseline has no carry bit, so the sample's carry naturally adds 2**(SUM_W-1) to the difference
  assign diff  = {1'b0, bus.in_sum} - {2'b00, base};
  assign err   = diff[SUM_W] || (diff[SUM_W-1:DELTA_W] != '0);
  assign delta = err ? '0 : diff[DELTA_W-1:0];

  // PRIME/RUN state machine and baseline capture; resync drops back to PRIME
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIME;
      primed_q <= 1'b0;
      base     <= '0;
    end else if (bus.resync) begin
      state    <= PRIME;
      primed_q <= 1'b0;
    end else if (accept) begin
      base     <= bus.in_sum[SUM_W-2:0];
      state    <= RUN;
      primed_q <= 1'b1;
    end
  end

  // Saturating count of illegal increments; survives resync
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (push && err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  // Output FIFO: push goes to head when it is (or becomes) free, otherwise to tail
  always_ff @(posedge clk) begin
    if (rst || bus.resync) begin
      count      <= 2'd0;
      head_delta <= '0;
      head_err   <= 1'b0;
      tail_delta <= '0;
      tail_err   <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_delta <= delta;
            head_err   <= err;
          end else begin
            tail_delta <= delta;
            tail_err   <= err;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_delta <= tail_delta;
          head_err   <= tail_err;
          count      <= count - 2'd1;
        end
        2'b11: begin
          head_delta <= delta;
          head_err   <= err;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_delta = head_delta;
  assign bus.out_err   = head_err;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.primed    = primed_q;

endmodule

// File: tb/tb_accum_delta_decoder.sv
// tb/tb_accum_delta_decoder.sv - directed self-checking bench for accum_delta_decoder
module tb_accum_delta_decoder;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  accum_delta_decoder_if #(.SUM_W(7), .DELTA_W(4), .CNT_W(8)) bus ();

  accum_delta_decoder #(.SUM_W(7), .DELTA_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] val);
    bus.in_valid = 1'b1;
    bus.in_sum   = val;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.resync   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sum   = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++;
    if (bus.primed !== 1'b0) $display("FAIL reset_primed: got %b want 0", bus.primed); else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); else n_pass++;
    n_total++;
    if (bus.out_delta !== 4'd0 || bus.out_err !== 1'b0)
      $display("FAIL reset_head: got delta=%0d err=%b want 0/0", bus.out_delta, bus.out_err);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    do_reset();
    bus.out_ready = 1'b0;
    send(7'h05);
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_prime_no_out: got %b want 0", bus.out_valid); else n_pass++;
    n_total++;
    if (bus.primed !== 1'b1) $display("FAIL basic_primed: got %b want 1", bus.primed); else n_pass++;
    send(7'h0C);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd7 || bus.out_err !== 1'b0)
      $display("FAIL basic_delta: got v=%b d=%0d e=%b want 1/7/0", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL basic_pop: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_carry_wrap();
    do_reset();
    bus.out_ready = 1'b1;
    send(7'd62);
    send(7'h4B);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd13 || bus.out_err !== 1'b0)
      $display("FAIL carry_first: got v=%b d=%0d e=%b want 1/13/0", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
    send(7'h19);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd14 || bus.out_err !== 1'b0)
      $display("FAIL carry_second: got v=%b d=%0d e=%b want 1/14/0", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL carry_drain: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    bus.out_ready = 1'b1;
    send(7'd10);
    send(7'h05);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_delta !== 4'd0)
      $display("FAIL illegal_neg: got v=%b d=%0d e=%b want 1/0/1", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd1) $display("FAIL illegal_cnt1: got %0d want 1", bus.err_cnt); else n_pass++;
    send(7'h25);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 || bus.out_delta !== 4'd0)
      $display("FAIL illegal_big: got v=%b d=%0d e=%b want 1/0/1", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd2) $display("FAIL illegal_cnt2: got %0d want 2", bus.err_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 1'b0;
    send(7'd0);
    send(7'd3);
    send(7'd5);
    bus.in_valid = 1'b1;
    bus.in_sum   = 7'd9;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL bp_full_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd3 || bus.in_ready !== 1'b0)
      $display("FAIL bp_hold: got v=%b d=%0d rdy=%b want 1/3/0", bus.out_valid, bus.out_delta, bus.in_ready);
    else n_pass++;
    bus.out_ready = 1'b1;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd2 || bus.in_ready !== 1'b1)
      $display("FAIL bp_pop1: got v=%b d=%0d rdy=%b want 1/2/1", bus.out_valid, bus.out_delta, bus.in_ready);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd4 || bus.out_err !== 1'b0)
      $display("FAIL bp_third: got v=%b d=%0d e=%b want 1/4/0", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_resync();
    do_reset();
    bus.out_ready = 1'b0;
    send(7'd10);
    send(7'd5);
    send(7'd8);
    n_total++;
    if (bus.err_cnt !== 8'd1) $display("FAIL resync_pre_cnt: got %0d want 1", bus.err_cnt); else n_pass++;
    bus.resync   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sum   = 7'h20;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL resync_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    tick();
    bus.resync   = 1'b0;
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.primed !== 1'b0)
      $display("FAIL resync_flush: got v=%b primed=%b want 0/0", bus.out_valid, bus.primed);
    else n_pass++;
    n_total++;
    if (bus.err_cnt !== 8'd1) $display("FAIL resync_cnt_kept: got %0d want 1", bus.err_cnt); else n_pass++;
    bus.out_ready = 1'b1;
    send(7'h10);
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.primed !== 1'b1)
      $display("FAIL resync_reprime: got v=%b primed=%b want 0/1", bus.out_valid, bus.primed);
    else n_pass++;
    send(7'h12);
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_delta !== 4'd2 || bus.out_err !== 1'b0)
      $display("FAIL resync_after: got v=%b d=%0d e=%b want 1/2/0", bus.out_valid, bus.out_delta, bus.out_err);
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1'b1;
    send(7'h3F);
    for (int i = 0; i < 300; i++) begin
      send((i % 2 == 0) ? 7'h00 : 7'h3F);
      if (i == 253) begin
        n_total++;
        if (bus.err_cnt !== 8'd254) $display("FAIL sat_254: got %0d want 254", bus.err_cnt); else n_pass++;
      end
      if (i == 254) begin
        n_total++;
        if (bus.err_cnt !== 8'd255) $display("FAIL sat_255: got %0d want 255", bus.err_cnt); else n_pass++;
      end
    end
    n_total++;
    if (bus.err_cnt !== 8'd255) $display("FAIL sat_hold: got %0d want 255", bus.err_cnt); else n_pass++;
    n_total++;
    if (bus.out_err !== 1'b1) $display("FAIL sat_err_flag: got %b want 1", bus.out_err); else n_pass++;
    do_reset();
    n_total++;
    if (bus.err_cnt !== 8'd0) $display("FAIL sat_reset: got %0d want 0", bus.err_cnt); else n_pass++;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.resync    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_carry_wrap();
    test_illegal();
    test_back_to_back();
    test_resync();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
